// File: rtl/mem_access_unit.sv
// mem_access_unit: single load/store sequencer between the address mux and a
// 32-bit word memory. Loads are sign/zero extended; sub-word stores are done
// as read-modify-write. Misaligned requests finish with err and touch nothing.
module mem_access_unit #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [2:0]  op,
  input  logic [31:0] wdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  op;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nx;
  req_t        req_q;
  logic [2:0]  cnt;
  logic        err_q;
  logic [31:0] mrg_q;
  logic        mis, is_load, rd_last, accept;

  // Extract the addressed half/byte of a little-endian word and extend it.
  function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] k,
                                           input logic [2:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {k, 3'b000});
    h = 16'(w >> {k[1], 4'b0000});
    case (o)
      OP_LH:   ext_load = {{16{h[15]}}, h};
      OP_LB:   ext_load = {{24{b[7]}}, b};
      OP_LHU:  ext_load = {16'b0, h};
      OP_LBU:  ext_load = {24'b0, b};
      default: ext_load = w;
    endcase
  endfunction

  // Replace the addressed half/byte of the read word with store data.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] k,
                                        input logic [2:0] o, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (o == OP_SH) r[{k[1], 4'b0000} +: 16] = d[15:0];
    else            r[{k, 3'b000} +: 8]      = d[7:0];
    merge = r;
  endfunction

  assign accept   = (state == IDLE) && start;
  assign is_load  = (req_q.op <= OP_LBU);
  assign rd_last  = (cnt == 3'(READ_LAT));
  assign mem_addr = {req_q.addr[31:2], 2'b00};
  // SW writes the latched data straight through; sub-word stores use the merged word
  assign mem_wdata = (req_q.op == OP_SW) ? req_q.wdata : mrg_q;

  // Alignment rule for the latched request
  always_comb begin
    mis = 1'b0;
    case (req_q.op)
      OP_LW, OP_SW:         mis = |req_q.addr[1:0];
      OP_LH, OP_LHU, OP_SH: mis = req_q.addr[0];
      default:              mis = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state and status outputs; misalignment is caught in the first busy cycle
  always_comb begin
    state_nx = state;
    mem_wr   = 1'b0;
    busy     = (state != IDLE);
    done     = (state == DONE);
    err      = (state == DONE) && err_q;
    case (state)
      IDLE:  if (start) state_nx = (op == OP_SW) ? WRITE : READ;
      READ: begin
        if (mis)          state_nx = DONE;
        else if (rd_last) state_nx = is_load ? DONE : WRITE;
      end
      WRITE: begin
        mem_wr   = !mis;
        state_nx = DONE;
      end
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch and error flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      req_q <= '{addr: addr, op: op, wdata: wdata};
      err_q <= 1'b0;
    end else if ((state == READ || state == WRITE) && mis) begin
      err_q <= 1'b1;
    end
  end

  // Read-phase cycle counter
  always_ff @(posedge clk) begin
    if (!reset_n)            cnt <= '0;
    else if (state == READ)  cnt <= cnt + 3'd1;
    else                     cnt <= '0;
  end

  // Capture read word on the last read cycle: extend for loads, merge for stores
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mrg_q     <= '0;
      load_data <= '0;
    end else if (state == READ && rd_last && !mis) begin
      if (is_load) load_data <= ext_load(mem_rdata, req_q.addr[1:0], req_q.op);
      else         mrg_q     <= merge(mem_rdata, req_q.addr[1:0], req_q.op, req_q.wdata);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_mem_access_unit;
  localparam int RL = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, s3;
  logic [31:0] addr, wdata;
  logic [2:0]  op;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, load_data;
  logic        mem_wr, busy, done, err;
  logic [31:0] mem_addr3, mem_wdata3, mem_rdata3, load_data3;
  logic        mem_wr3, busy3, done3, err3;

  mem_access_unit #(.READ_LAT(RL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .addr(addr), .op(op), .wdata(wdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .load_data(load_data), .busy(busy), .done(done), .err(err));

  mem_access_unit #(.READ_LAT(3)) u3 (
    .clk(clk), .reset_n(reset_n), .start(s3), .addr(addr), .op(op), .wdata(wdata),
    .mem_addr(mem_addr3), .mem_wr(mem_wr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .load_data(load_data3), .busy(busy3), .done(done3), .err(err3));

  // Word memories with fixed read latency
  logic [31:0] mem [64];
  logic [31:0] mem3 [64];
  logic [31:0] refm [64];
  logic [31:0] rq [RL];
  logic [31:0] rq3 [3];
  assign mem_rdata  = rq[RL-1];
  assign mem_rdata3 = rq3[2];

  always @(posedge clk) begin
    rq[0] <= mem[mem_addr[7:2]];
    for (int i = 1; i < RL; i++) rq[i] <= rq[i-1];
    if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
  end

  always @(posedge clk) begin
    rq3[0] <= mem3[mem_addr3[7:2]];
    rq3[1] <= rq3[0];
    rq3[2] <= rq3[1];
    if (mem_wr3) mem3[mem_addr3[7:2]] <= mem_wdata3;
  end

  int nchk = 0, nerr = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Specification-level rules
  function automatic bit is_mis(input logic [31:0] a, input logic [2:0] o);
    case (o)
      3'd0, 3'd5:       return a[1:0] != 2'd0;
      3'd1, 3'd3, 3'd6: return a[0];
      default:          return 1'b0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input bit m);
    if (m)         return 2;
    if (o <= 3'd4) return RL + 2;
    if (o == 3'd5) return 2;
    return RL + 3;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] k,
                                           input logic [2:0] o);
    logic [31:0] b, h;
    b = (w >> (8 * k)) & 32'hFF;
    h = (w >> (16 * k[1])) & 32'hFFFF;
    case (o)
      3'd1:    return h[15] ? (h | 32'hFFFF0000) : h;
      3'd2:    return b[7]  ? (b | 32'hFFFFFF00) : b;
      3'd3:    return h;
      3'd4:    return b;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_merge(input logic [31:0] w, input logic [1:0] k,
                                            input logic [2:0] o, input logic [31:0] d);
    logic [31:0] m;
    if (o == 3'd6) begin
      m = 32'hFFFF << (16 * k[1]);
      return (w & ~m) | ((d & 32'hFFFF) << (16 * k[1]));
    end
    if (o == 3'd7) begin
      m = 32'hFF << (8 * k);
      return (w & ~m) | ((d & 32'hFF) << (8 * k));
    end
    return d;
  endfunction

  // Transaction model: one outstanding request, timing from the latency table
  logic        active;
  int          t0, lat_e;
  logic        e_err, e_st;
  logic [31:0] e_wd, ld_b, ld_a, maq;
  logic [5:0]  widx;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) begin
      active <= 1'b0;
      ld_b   <= '0;
      ld_a   <= '0;
      maq    <= '0;
    end else begin
      if (active && cyc == t0 + lat_e - 1 && e_st && !e_err) refm[widx] <= e_wd;
      if (start && (!active || cyc > t0 + lat_e)) begin
        active <= 1'b1;
        t0     <= cyc;
        e_err  <= is_mis(addr, op);
        lat_e  <= exp_lat(op, is_mis(addr, op));
        e_st   <= (op >= 3'd5);
        widx   <= addr[7:2];
        maq    <= {addr[31:2], 2'b00};
        e_wd   <= exp_merge(refm[addr[7:2]], addr[1:0], op, wdata);
        ld_b   <= ld_a;
        if (op <= 3'd4 && !is_mis(addr, op)) ld_a <= exp_load(refm[addr[7:2]], addr[1:0], op);
      end
    end
  end

  // Per-cycle compare against the model
  logic chk_en = 1'b0;
  always @(negedge clk) begin : cmp
    int   rel;
    bit   inb, xwr;
    if (chk_en) begin
      rel = cyc - t0;
      inb = active && rel >= 1 && rel <= lat_e;
      xwr = inb && e_st && !e_err && rel == lat_e - 1;
      chk("busy", {31'b0, busy}, {31'b0, inb});
      chk("done", {31'b0, done}, {31'b0, inb && rel == lat_e});
      chk("err", {31'b0, err}, {31'b0, inb && rel == lat_e && e_err});
      chk("mem_wr", {31'b0, mem_wr}, {31'b0, xwr});
      chk("mem_addr", mem_addr, maq);
      chk("load_data", load_data, (inb && rel < lat_e) ? ld_b : ld_a);
      if (xwr) chk("mem_wdata", mem_wdata, e_wd);
    end
  end

  // Event counters for directed checks
  int wr_cnt = 0, done_cnt = 0;
  logic [31:0] last_wd;
  always @(negedge clk) begin
    if (mem_wr) begin
      wr_cnt++;
      last_wd = mem_wdata;
    end
    if (done) done_cnt++;
  end

  task automatic issue(input logic [31:0] a, input logic [2:0] o, input logic [31:0] wd,
                       input bit hold, output int lat, output logic e);
    @(posedge clk); #1;
    addr = a; op = o; wdata = wd; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
    e = err;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int lat, w0, d0;
    logic e;
    reset_n = 1'b0; start = 1'b0; s3 = 1'b0;
    addr = '0; op = '0; wdata = '0;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] v;
      v = (i == 4) ? 32'h8899AABB : $urandom;
      mem[i]  <= v;
      refm[i] <= v;
      mem3[i] <= v;
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst err", {31'b0, err}, 32'd0);
    chk("rst mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst load_data", load_data, 32'd0);

    issue(32'h10, 3'd0, 32'h0, 1'b0, lat, e);
    chk("lw lat", lat, 3);
    chk("lw data", load_data, 32'h8899AABB);
    issue(32'h11, 3'd2, 32'h0, 1'b0, lat, e);
    chk("lb data", load_data, 32'hFFFFFFAA);
    issue(32'h11, 3'd4, 32'h0, 1'b0, lat, e);
    chk("lbu data", load_data, 32'h000000AA);
    issue(32'h12, 3'd1, 32'h0, 1'b0, lat, e);
    chk("lh data", load_data, 32'hFFFF8899);

    w0 = wr_cnt;
    issue(32'h12, 3'd7, 32'h55, 1'b0, lat, e);
    chk("sb lat", lat, 4);
    chk("sb wr count", wr_cnt - w0, 1);
    chk("sb wdata", last_wd, 32'h8855AABB);
    chk("sb keeps load_data", load_data, 32'hFFFF8899);
    issue(32'h10, 3'd0, 32'h0, 1'b0, lat, e);
    chk("lw after sb", load_data, 32'h8855AABB);

    w0 = wr_cnt;
    issue(32'h13, 3'd5, 32'h12345678, 1'b0, lat, e);
    chk("sw mis lat", lat, 2);
    chk("sw mis err", {31'b0, e}, 32'd1);
    chk("sw mis no write", wr_cnt - w0, 0);
    chk("sw mis load_data", load_data, 32'h8855AABB);
    issue(32'h11, 3'd1, 32'h0, 1'b0, lat, e);
    chk("lh mis lat", lat, 2);
    chk("lh mis err", {31'b0, e}, 32'd1);
    chk("lh mis load_data", load_data, 32'h8855AABB);

    w0 = wr_cnt; d0 = done_cnt;
    issue(32'h10, 3'd6, 32'hABCD1234, 1'b1, lat, e);
    repeat (3) @(negedge clk);
    chk("sh held lat", lat, 4);
    chk("sh held wr count", wr_cnt - w0, 1);
    chk("sh held done count", done_cnt - d0, 1);
    chk("sh wdata", last_wd, 32'h88551234);

    // Reset while an SB is still reading: the write must never happen
    w0 = wr_cnt;
    @(posedge clk); #1;
    addr = 32'h12; op = 3'd7; wdata = 32'h66; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst mid busy", {31'b0, busy}, 32'd0);
    chk("rst mid done", {31'b0, done}, 32'd0);
    chk("rst mid load_data", load_data, 32'd0);
    repeat (4) @(negedge clk);
    chk("rst mid no write", wr_cnt - w0, 0);
    issue(32'h10, 3'd0, 32'h0, 1'b0, lat, e);
    chk("lw after abort", load_data, 32'h88551234);

    // Same load on the READ_LAT=3 instance
    @(posedge clk); #1;
    addr = 32'h10; op = 3'd0; s3 = 1'b1;
    @(posedge clk); #1;
    s3 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done3 && lat < 20);
    chk("rl3 lw lat", lat, 5);
    chk("rl3 lw data", load_data3, 32'h8899AABB);

    // Random traffic; starts while busy must be ignored by both DUT and model
    repeat (3000) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      addr  = $urandom_range(0, 255);
      op    = 3'($urandom);
      wdata = $urandom;
    end
    #0 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
